// File: rtl/barrel_shifter_pkg.sv
// Shared mode encoding and fill-bit helper for the barrel shifter.
package barrel_shifter_pkg;

  typedef enum logic [2:0] {
    MODE_ROL = 3'b000,
    MODE_ROR = 3'b001,
    MODE_LSL = 3'b010,
    MODE_LSR = 3'b011,
    MODE_ASR = 3'b100
  } mode_e;

  // Only arithmetic right shift replicates the sign bit; every other shift zero-fills.
  function automatic logic fill_bit(input logic [2:0] mode, input logic msb);
    return (mode == MODE_ASR) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One mux level of the shifter: left-moves data by DIST when en is set.
// Combinational; no backpressure.
module barrel_stage #(
  parameter int WIDTH = 4,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             rotate,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  logic [DIST-1:0] low_bits;

  // Rotates recirculate the bits pushed off the top; shifts inject the fill bit.
  assign low_bits = rotate ? data[WIDTH-1 -: DIST] : {DIST{fill}};
  assign result   = en ? {data[WIDTH-DIST-1:0], low_bits} : data;

endmodule

// File: rtl/barrel_shifter.sv
// Variable-distance shift/rotate with a registered output.
// Latency 1 cycle, one result per cycle, no backpressure.
module barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shift,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic                       is_right;
  logic                       rotate;
  logic                       pass;
  logic                       fill;
  logic [WIDTH-1:0]           core_in;
  logic [WIDTH-1:0]           result;
  logic [SHW:0][WIDTH-1:0]    stage_dat;

  always_comb begin
    is_right = 1'b0;
    rotate   = 1'b0;
    pass     = 1'b0;
    case (mode)
      MODE_ROL: rotate = 1'b1;
      MODE_ROR: begin
        rotate   = 1'b1;
        is_right = 1'b1;
      end
      MODE_LSL: ;
      MODE_LSR,
      MODE_ASR: is_right = 1'b1;
      default:  pass = 1'b1;
    endcase
  end

  assign fill = fill_bit(mode, in[WIDTH-1]);

  // Right operations reuse the left-moving core by reversing bit order on both sides.
  always_comb begin
    core_in = in;
    if (is_right) begin
      for (int i = 0; i < WIDTH; i++) core_in[i] = in[WIDTH-1-i];
    end
  end

  assign stage_dat[0] = core_in;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH(WIDTH),
      .DIST (1 << k)
    ) u_stage (
      .data  (stage_dat[k]),
      .en    (shift[k] & ~pass),
      .rotate(rotate),
      .fill  (fill),
      .result(stage_dat[k+1])
    );
  end

  always_comb begin
    result = stage_dat[SHW];
    if (is_right) begin
      for (int i = 0; i < WIDTH; i++) result[i] = stage_dat[SHW][WIDTH-1-i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= result;
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed and exhaustive checks of barrel_shifter at WIDTH=4 and WIDTH=8.
module tb_barrel_shifter;

  logic       clk;
  logic       rst_n;
  logic       v4, v8;
  logic [3:0] in4;
  logic [1:0] sh4;
  logic [2:0] m4;
  logic [3:0] out4;
  logic       ov4;
  logic [7:0] in8;
  logic [2:0] sh8;
  logic [2:0] m8;
  logic [7:0] out8;
  logic       ov8;

  int checks = 0;
  int errors = 0;

  barrel_shifter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in(in4), .shift(sh4), .mode(m4),
    .out(out4), .out_valid(ov4)
  );

  barrel_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in(in8), .shift(sh8), .mode(m8),
    .out(out8), .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Bit-placement reference, written independently of the mux-chain structure.
  function automatic logic [7:0] ref_model(input int w, input logic [7:0] a,
                                           input int s, input logic [2:0] m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        3'b000: r[(i + s) % w] = a[i];
        3'b001: r[i] = a[(i + s) % w];
        3'b010: r[i] = (i >= s) ? a[i - s] : 1'b0;
        3'b011: r[i] = (i + s < w) ? a[i + s] : 1'b0;
        3'b100: r[i] = (i + s < w) ? a[i + s] : a[w-1];
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  task automatic run(input int w, input logic [2:0] m, input logic [7:0] a,
                     input int s, input logic [7:0] exp, input string tag);
    @(negedge clk);
    if (w == 4) begin
      v4 = 1'b1; v8 = 1'b0;
      in4 = a[3:0]; sh4 = 2'(s); m4 = m;
    end else begin
      v4 = 1'b0; v8 = 1'b1;
      in8 = a; sh8 = 3'(s); m8 = m;
    end
    @(posedge clk);
    #1;
    if (w == 4) begin
      chk({tag, ".out"}, {4'b0, out4}, exp);
      chk({tag, ".vld"}, {7'b0, ov4}, 8'd1);
    end else begin
      chk({tag, ".out"}, out8, exp);
      chk({tag, ".vld"}, {7'b0, ov8}, 8'd1);
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [2:0] m;
    int         s;
    rst_n = 1'b1; v4 = 1'b0; v8 = 1'b0;
    in4 = '0; sh4 = '0; m4 = '0; in8 = '0; sh8 = '0; m8 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.out", {4'b0, out4}, 8'h00);
    chk("rst.vld", {7'b0, ov4}, 8'h00);
    rst_n = 1'b1;

    // Load a nonzero result, then reset asynchronously between edges.
    run(4, 3'b000, 8'h0d, 1, 8'h0b, "preload");
    @(negedge clk); v4 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async.out", {4'b0, out4}, 8'h00);
    chk("async.vld", {7'b0, ov4}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release.vld", {7'b0, ov4}, 8'h00);
    chk("release.out", {4'b0, out4}, 8'h00);

    // Back-to-back directed vectors, streamed with in_valid held high.
    run(4, 3'b000, 8'h0d, 0, 8'h0d, "rol1101s0");
    run(4, 3'b000, 8'h0d, 1, 8'h0b, "rol1101s1");
    run(4, 3'b000, 8'h0d, 2, 8'h07, "rol1101s2");
    run(4, 3'b000, 8'h0d, 3, 8'h0e, "rol1101s3");
    run(4, 3'b000, 8'h0a, 0, 8'h0a, "rol1010s0");
    run(4, 3'b000, 8'h0a, 1, 8'h05, "rol1010s1");
    run(4, 3'b000, 8'h0a, 2, 8'h0a, "rol1010s2");
    run(4, 3'b000, 8'h0a, 3, 8'h05, "rol1010s3");
    run(4, 3'b001, 8'h0d, 1, 8'h0e, "ror1101s1");
    run(4, 3'b010, 8'h0d, 1, 8'h0a, "lsl1101s1");
    run(4, 3'b011, 8'h0d, 2, 8'h03, "lsr1101s2");
    run(4, 3'b100, 8'h0a, 1, 8'h0d, "asr1010s1");
    run(4, 3'b100, 8'h06, 3, 8'h00, "asr0110s3");
    run(4, 3'b111, 8'h09, 2, 8'h09, "pass1001s2");

    // Idle cycle: valid drops, data holds.
    @(negedge clk); v4 = 1'b0; in4 = 4'h6; sh4 = 2'd1; m4 = 3'b000;
    @(posedge clk); #1;
    chk("hold.vld", {7'b0, ov4}, 8'h00);
    chk("hold.out", {4'b0, out4}, 8'h09);

    for (int ai = 0; ai < 16; ai++)
      for (int si = 0; si < 4; si++)
        for (int mi = 0; mi < 8; mi++) begin
          a = 8'(ai); m = 3'(mi); s = si;
          run(4, m, a, s, ref_model(4, a, s, m), $sformatf("ex4.m%0d.a%h.s%0d", mi, ai, si));
        end

    run(8, 3'b001, 8'h81, 3, 8'h30, "w8.ror81s3");
    run(8, 3'b000, 8'h81, 1, 8'h03, "w8.rol81s1");
    run(8, 3'b100, 8'h90, 4, 8'hf9, "w8.asr90s4");
    run(8, 3'b011, 8'h90, 7, 8'h01, "w8.lsr90s7");
    run(8, 3'b010, 8'hff, 7, 8'h80, "w8.lslffs7");
    for (int n = 0; n < 200; n++) begin
      a = 8'($urandom); m = 3'($urandom_range(7)); s = $urandom_range(7);
      run(8, m, a, s, ref_model(8, a, s, m), $sformatf("rnd8.m%0d.a%h.s%0d", m, a, s));
    end

    @(negedge clk); v8 = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
Parameterised single-cycle barrel shifter/rotator with a registered output. It is used by datapath blocks that need a variable-distance shift or rotate with a 1-cycle latency. Internally it is a log2(WIDTH)-stage mux network followed by one output register. The default 4-bit configuration gives rotate-left results for shift distances 0..3.

Parameters:
- WIDTH, 4, data width in bits; must be a power of two, at least 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in/shift/mode this cycle.
- in  input  WIDTH  operand.
- shift  input  SHW  shift/rotate distance, 0..WIDTH-1.
- mode  input  3  operation select (see Behaviour).
- out  output  WIDTH  registered result.
- out_valid  output  1  high for one cycle when out holds a new result.

Behaviour:
- Reset: rst_n low clears out to 0 and out_valid to 0 immediately, without waiting for a clock edge. Release is synchronous to clk.
- Latency: exactly 1 cycle. A sample accepted at edge N (in_valid=1) appears on out with out_valid=1 after edge N.
- in_valid=0 at an edge: out_valid goes to 0 and out holds its previous value.
- Back-to-back: one result per cycle, no stall, no backpressure.
- mode encoding:
  - 000 ROL: rotate left. Bit i moves to (i+shift) mod WIDTH.
  - 001 ROR: rotate right.
  - 010 LSL: logical shift left, zero fill.
  - 011 LSR: logical shift right, zero fill.
  - 100 ASR: arithmetic shift right, MSB fill.
  - 101..111: pass-through, out = in.
- shift=0: out = in for every mode.
- Shift amount is SHW bits wide, so no out-of-range distance exists. Wrap-around applies only in the rotate modes.
- Datapath:
  - Stage k (k = 0..SHW-1) conditionally moves data by 2^k when shift[k]=1.
  - Right operations use bit reversal around a left-shift core, or dedicated right muxes; either is acceptable.
  - Fill bit is 0 for logical modes and in[WIDTH-1] for ASR. Rotate modes feed the bits shifted out back in.
- Reset mid-operation: any in-flight result is discarded and out_valid=0 on the first edge after release unless in_valid=1 at that edge.
- No X propagation: out is fully defined whenever in and shift are defined.

Decomposition:
- Package barrel_shifter_pkg:
  - mode enum: MODE_ROL, MODE_ROR, MODE_LSL, MODE_LSR, MODE_ASR.
  - Helper function for fill-bit selection.
- Sub-module barrel_stage:
  - Parameters WIDTH and DIST (2^k).
  - Inputs: data, en, rotate flag, fill bit. Output: data after one stage.
  - Instantiated SHW times in a generate loop.
- Top level contains mode decode, stage chain and output register.

Test Plan:
- Reset: assert rst_n=0 while out is nonzero -> out=0000, out_valid=0 with no clock edge needed. Deassert with in_valid=0 -> out_valid stays 0.
- ROL, in=1101: shift 00/01/10/11 -> out 1101/1011/0111/1110, each one cycle after acceptance with out_valid=1.
- ROL, in=1010: shift 00/01/10/11 -> out 1010/0101/1010/0101. Then ROR, in=1101, shift=01 -> 1110.
- Shifts, in=1101:
  - LSL shift=01 -> 1010.
  - LSR shift=10 -> 0011.
  - ASR shift=01 on in=1010 -> 1101.
  - ASR shift=11 on in=0110 -> 0000.
- Streaming and hold: 4 back-to-back valid samples -> 4 consecutive out_valid pulses with matching results. Then in_valid=0 -> out_valid=0 and out holds the last result. mode=111 with in=1001, shift=10 -> out=1001.
- Exhaustive: all 16 values of in × 4 shifts × 8 modes against a reference model. Repeat at WIDTH=8, e.g. ROR 0x81 by 3 -> 0x30.
